// File: rtl/adc_averager_if.sv
// adc_averager_if: ADC trigger/sample link plus the averaged-result valid/ready stream.
// master = averager side, slave = SPI reader / consumer side.
interface adc_averager_if #(
  parameter int unsigned DATA_W = 16
);
  logic              start_conversion;
  logic [DATA_W-1:0] adc_data;
  logic              data_ready;
  logic [DATA_W-1:0] avg_data;
  logic              avg_valid;
  logic              avg_ready;

  modport master (
    output start_conversion,
    input  adc_data,
    input  data_ready,
    output avg_data,
    output avg_valid,
    input  avg_ready
  );

  modport slave (
    input  start_conversion,
    output adc_data,
    output data_ready,
    input  avg_data,
    input  avg_valid,
    output avg_ready
  );
endinterface

// File: rtl/adc_averager.sv
// adc_averager: triggers periodic ADC conversions, averages 2^LOG2_AVG samples and offers
// the mean over valid/ready. Define ADC_AVG_MINMAX_EN to build per-batch min/max tracking.
module adc_averager #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LOG2_AVG = 3,
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  adc_averager_if.master    bus,
  input  logic              clear_err,
  output logic              overrun,
  output logic              timeout_err,
  output logic [DATA_W-1:0] batch_min,
  output logic [DATA_W-1:0] batch_max
);

  localparam int unsigned ACC_W = DATA_W + LOG2_AVG;
  localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CONVERT
  } state_t;

  state_t            state;
  logic [PER_W-1:0]  per_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              drop_pend;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  logic              tick_c;
  logic              in_conv_c;
  logic              accept_c;
  logic              tmo_hit_c;
  logic              done_c;
  logic              load_c;
  logic [ACC_W-1:0]  sum_c;
  logic [DATA_W-1:0] mean_c;

  assign tick_c    = enable && (per_cnt == PER_LAST);
  assign in_conv_c = (state == S_CONVERT);
  // A sample counts only if sampling stayed enabled for the whole conversion.
  assign accept_c  = in_conv_c && bus.data_ready && enable && !drop_pend;
  assign tmo_hit_c = in_conv_c && !bus.data_ready && (tmo_cnt == TMO_LAST);
  assign done_c    = accept_c && (cnt == LAST_IDX);
  assign load_c    = done_c && (!bus.avg_valid || bus.avg_ready);
  assign sum_c     = acc + ACC_W'(bus.adc_data);
  assign mean_c    = DATA_W'(sum_c >> LOG2_AVG);

  // Free-running trigger period, held at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
    end else if (!enable || tick_c) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  // Conversion sequencing; ticks landing in CONVERT are skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      bus.start_conversion <= 1'b0;
      tmo_cnt              <= '0;
      drop_pend            <= 1'b0;
    end else begin
      bus.start_conversion <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (tick_c) begin
            bus.start_conversion <= 1'b1;
            tmo_cnt              <= '0;
            drop_pend            <= 1'b0;
            state                <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (!enable) drop_pend <= 1'b1;
          if (bus.data_ready || tmo_hit_c) begin
            state <= S_WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Batch accumulation; the accumulator is wide enough never to wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (!enable || done_c) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept_c) begin
      acc <= sum_c;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Result register: a full holding register drops new results and flags overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.avg_data  <= '0;
      bus.avg_valid <= 1'b0;
    end else if (load_c) begin
      bus.avg_data  <= mean_c;
      bus.avg_valid <= 1'b1;
    end else if (bus.avg_valid && bus.avg_ready) begin
      bus.avg_valid <= 1'b0;
    end
  end

  // Sticky error flags; clear_err has priority over a same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (clear_err) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (done_c && bus.avg_valid && !bus.avg_ready) overrun <= 1'b1;
      if (tmo_hit_c) timeout_err <= 1'b1;
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] nxt_min_c;
  logic [DATA_W-1:0] nxt_max_c;
  logic              first_c;

  assign first_c   = (cnt == '0);
  assign nxt_min_c = (first_c || (bus.adc_data < run_min)) ? bus.adc_data : run_min;
  assign nxt_max_c = (first_c || (bus.adc_data > run_max)) ? bus.adc_data : run_max;

  // Running extremes re-seed on the first sample of every batch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_min   <= '0;
      run_max   <= '0;
      batch_min <= '0;
      batch_max <= '0;
    end else begin
      if (accept_c) begin
        run_min <= nxt_min_c;
        run_max <= nxt_max_c;
      end
      if (load_c) begin
        batch_min <= nxt_min_c;
        batch_max <= nxt_max_c;
      end
    end
  end
`else
  assign batch_min = '0;
  assign batch_max = '0;
`endif

endmodule

// File: tb/tb_adc_averager.sv
// Bench for adc_averager: directed scenarios driven through a delayed ADC responder,
// a cycle-level reference model of the averaging rules, and literal per-scenario expectations.
module tb_adc_averager;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned LOG2_AVG = 2;
  localparam int unsigned PERIOD   = 64;
  localparam int unsigned TIMEOUT  = 255;
  localparam int          NAVG     = 4;
  localparam int          RESP_DLY = 36;
`ifdef ADC_AVG_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              clear_err;
  logic              overrun;
  logic              timeout_err;
  logic [DATA_W-1:0] batch_min;
  logic [DATA_W-1:0] batch_max;

  adc_averager_if #(.DATA_W(DATA_W)) bus ();

  adc_averager #(
    .DATA_W  (DATA_W),
    .LOG2_AVG(LOG2_AVG),
    .PERIOD  (PERIOD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bus        (bus),
    .clear_err  (clear_err),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .batch_min  (batch_min),
    .batch_max  (batch_max)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;

  // ADC responder: answers each trigger with the next queued sample RESP_DLY cycles later.
  logic [DATA_W-1:0] feed_q[$];
  bit                resp_busy = 1'b0;
  int                resp_cnt  = 0;
  logic [DATA_W-1:0] resp_sample = '0;

  // Reference model state.
  int batch_q[$];
  bit m_start   = 1'b0;
  bit m_valid   = 1'b0;
  bit m_ovr     = 1'b0;
  bit m_tmo     = 1'b0;
  bit m_pending = 1'b0;
  bit m_dropped = 1'b0;
  int m_data    = 0;
  int m_min     = 0;
  int m_max     = 0;
  int m_trig    = 0;
  int en_run    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc_n, act, exp);
  endtask

  function automatic logic [63:0] dut_vec();
    return {12'h0, bus.start_conversion, bus.avg_valid, bus.avg_data,
            overrun, timeout_err, batch_min, batch_max};
  endfunction

  function automatic logic [63:0] model_vec();
    logic [15:0] mn;
    logic [15:0] mx;
    mn = MINMAX ? 16'(m_min) : 16'h0;
    mx = MINMAX ? 16'(m_max) : 16'h0;
    return {12'h0, m_start, m_valid, 16'(m_data), m_ovr, m_tmo, mn, mx};
  endfunction

  // Outputs expected after this clock edge, from the inputs seen at the edge.
  task automatic model_edge();
    bit pend_b, tick, accept, complete, ovr_set, tmo_set;
    int sum, mn, mx;
    accept = 0; complete = 0; ovr_set = 0; tmo_set = 0;
    sum = 0; mn = 0; mx = 0;
    if (!reset_n) begin
      m_start = 0; m_valid = 0; m_data = 0; m_min = 0; m_max = 0;
      m_ovr = 0; m_tmo = 0; m_pending = 0; m_dropped = 0; en_run = 0;
      batch_q.delete();
    end else begin
      pend_b  = m_pending;
      tick    = enable && (en_run == int'(PERIOD) - 1);
      m_start = 0;
      if (m_pending) begin
        if (!enable) m_dropped = 1;
        if (bus.data_ready) begin
          accept    = enable && !m_dropped;
          m_pending = 0;
        end else if (cyc_n - m_trig == int'(TIMEOUT) - 1) begin
          tmo_set   = 1;
          m_pending = 0;
        end
      end
      if (tick && !pend_b) begin
        m_start = 1; m_pending = 1; m_dropped = 0; m_trig = cyc_n + 1;
      end
      en_run = enable ? (en_run + 1) % int'(PERIOD) : 0;
      if (!enable) batch_q.delete();
      if (accept) begin
        batch_q.push_back(int'(bus.adc_data));
        if (batch_q.size() == NAVG) begin
          mn = batch_q[0];
          mx = batch_q[0];
          foreach (batch_q[i]) begin
            sum += batch_q[i];
            if (batch_q[i] < mn) mn = batch_q[i];
            if (batch_q[i] > mx) mx = batch_q[i];
          end
          complete = 1;
          batch_q.delete();
        end
      end
      if (complete) begin
        if (!m_valid || bus.avg_ready) begin
          m_valid = 1; m_data = sum >> LOG2_AVG; m_min = mn; m_max = mx;
        end else begin
          ovr_set = 1;
        end
      end else if (m_valid && bus.avg_ready) begin
        m_valid = 0;
      end
      if (clear_err) begin
        m_ovr = 0; m_tmo = 0;
      end else begin
        if (ovr_set) m_ovr = 1;
        if (tmo_set) m_tmo = 1;
      end
    end
  endtask

  // One clock: model update at the edge, compare on the falling edge, then drive the ADC.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    cyc_n++;
    @(negedge clk);
    chk("cycle", dut_vec(), model_vec());
    bus.data_ready = 1'b0;
    if (resp_busy) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.data_ready = 1'b1;
        bus.adc_data   = resp_sample;
        resp_busy      = 1'b0;
      end
    end
    if (bus.start_conversion && !resp_busy && feed_q.size() > 0) begin
      resp_sample = feed_q.pop_front();
      resp_cnt    = RESP_DLY;
      resp_busy   = 1'b1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k = 0;
    while (!bus.avg_valid && k < budget) begin cyc(); k++; end
    chk(nm, 64'(bus.avg_valid), 64'd1);
  endtask

  task automatic wait_start(input int budget, input string nm);
    int k = 0;
    while (!bus.start_conversion && k < budget) begin cyc(); k++; end
    chk(nm, 64'(bus.start_conversion), 64'd1);
  endtask

  task automatic wait_popped(input int budget, input string nm);
    int k = 0;
    while (feed_q.size() > 0 && k < budget) begin cyc(); k++; end
    chk(nm, 64'(feed_q.size()), 64'd0);
  endtask

  task automatic wait_drained(input int budget, input string nm);
    int k = 0;
    while ((feed_q.size() > 0 || resp_busy) && k < budget) begin cyc(); k++; end
    chk(nm, 64'(feed_q.size() > 0 || resp_busy), 64'd0);
  endtask

  initial begin
    int t0;
    int starts;
    int k;
    reset_n = 1'b0; enable = 1'b0; clear_err = 1'b0;
    bus.adc_data = '0; bus.data_ready = 1'b0; bus.avg_ready = 1'b0;

    run(3);
    chk("reset_outputs", dut_vec(), 64'h0);
    reset_n = 1'b1;
    run(2);

    // Basic average: (100+200+300+400)/4 = 250.
    bus.avg_ready = 1'b1; enable = 1'b1;
    feed_q = '{16'd100, 16'd200, 16'd300, 16'd400};
    wait_valid(600, "avg250_valid");
    chk("avg250_data", 64'(bus.avg_data), 64'd250);
    chk("avg250_model", 64'(m_data), 64'd250);
    chk("avg250_min", 64'(batch_min), MINMAX ? 64'd100 : 64'd0);
    chk("avg250_max", 64'(batch_max), MINMAX ? 64'd400 : 64'd0);
    enable = 1'b0;
    run(1);
    chk("avg250_handshake_drop", 64'(bus.avg_valid), 64'd0);
    run(2);

    // Truncation: 7/4 -> 1.
    enable = 1'b1;
    feed_q = '{16'd1, 16'd2, 16'd2, 16'd2};
    wait_valid(600, "trunc_valid");
    chk("trunc_data", 64'(bus.avg_data), 64'd1);
    enable = 1'b0;
    run(3);

    // Full-scale: no accumulator wrap.
    enable = 1'b1;
    feed_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    wait_valid(600, "full_valid");
    chk("full_data", 64'(bus.avg_data), 64'hFFFF);
    chk("full_no_tmo", 64'(timeout_err), 64'd0);
    enable = 1'b0;
    run(3);

    // Overrun: second batch dropped while first is unaccepted.
    bus.avg_ready = 1'b0; enable = 1'b1;
    feed_q = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd50, 16'd50, 16'd50, 16'd50};
    wait_drained(1000, "ovr_drain");
    run(3);
    chk("ovr_valid", 64'(bus.avg_valid), 64'd1);
    chk("ovr_data_kept", 64'(bus.avg_data), 64'd10);
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_min_kept", 64'(batch_min), MINMAX ? 64'd10 : 64'd0);
    enable = 1'b0;
    bus.avg_ready = 1'b1;
    chk("ovr_accept_10", 64'(bus.avg_data), 64'd10);
    run(1);
    chk("ovr_valid_drop", 64'(bus.avg_valid), 64'd0);
    clear_err = 1'b1;
    run(1);
    clear_err = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);
    run(2);

    // Timeout: flag 255 cycles after an unanswered trigger, then retrigger; count unaffected.
    enable = 1'b1;
    wait_start(200, "tmo_trigger");
    t0 = cyc_n;
    k = 0;
    while (!timeout_err && k < 400) begin cyc(); k++; end
    chk("tmo_set", 64'(timeout_err), 64'd1);
    chk("tmo_latency", 64'(cyc_n - t0), 64'd255);
    feed_q = '{16'd20, 16'd20, 16'd20, 16'd40};
    wait_start(80, "tmo_retrigger");
    wait_valid(600, "tmo_batch_valid");
    chk("tmo_batch_data", 64'(bus.avg_data), 64'd25);
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
    enable = 1'b0;
    clear_err = 1'b1;
    run(1);
    clear_err = 1'b0;
    chk("tmo_cleared", 64'(timeout_err), 64'd0);
    run(2);

    // Enable drop: partial batch and in-flight sample discarded, no triggers while off.
    enable = 1'b1;
    feed_q = '{16'd7, 16'd7, 16'd99};
    wait_popped(300, "drop_third_trigger");
    run(10);
    enable = 1'b0;
    starts = 0;
    repeat (100) begin
      cyc();
      if (bus.start_conversion) starts++;
    end
    chk("drop_no_start", 64'(starts), 64'd0);
    chk("drop_no_valid", 64'(bus.avg_valid), 64'd0);
    enable = 1'b1;
    feed_q = '{16'd80, 16'd80, 16'd80, 16'd80};
    wait_valid(600, "drop_valid");
    chk("drop_data", 64'(bus.avg_data), 64'd80);
    enable = 1'b0;
    run(3);

    // Reset in the middle of a conversion: outputs clear at once, stale samples lost.
    enable = 1'b1;
    feed_q = '{16'd60, 16'd60, 16'd60};
    wait_popped(300, "rst_third_trigger");
    run(5);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outputs", dut_vec(), 64'h0);
    resp_busy = 1'b0;
    feed_q.delete();
    bus.data_ready = 1'b0;
    run(3);
    reset_n = 1'b1;
    feed_q = '{16'd30, 16'd30, 16'd30, 16'd30};
    wait_valid(600, "rst_fresh_valid");
    chk("rst_fresh_data", 64'(bus.avg_data), 64'd30);
    enable = 1'b0;
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
